// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end. Owns the fetch PC, issues sequential requests
// to instruction memory over a valid/ready handshake, and buffers returned
// instructions (tagged with their PC) in a DEPTH-entry FIFO that decode drains
// through a valid/ready port. A redirect flushes the FIFO, restarts fetch at
// the new PC and discards every response that was already in flight.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When the FIFO is empty and a live response arrives, that response drives
//   out_valid/out_pc/out_inst combinationally in the same cycle. If decode
//   takes it (out_ready) it is never written into the FIFO.
//   Without the macro there is no combinational path from imem_resp_* to
//   out_*; response-to-output latency is always one cycle.
//
// Parameters:
//   XLEN      PC / address width
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-high reset
//   imem_req_valid   fetch request valid (credit limited)
//   imem_req_ready   memory accepts request
//   imem_req_addr    fetch address (current fetch PC)
//   imem_resp_valid  in-order instruction return, >= 1 cycle after acceptance
//   imem_resp_inst   returned instruction
//   redirect_valid   flush and restart fetch
//   redirect_pc      new fetch PC (4-byte aligned)
//   out_valid        queue head valid
//   out_ready        decode consumes head
//   out_pc           head PC
//   out_inst         head instruction
//   count            occupied FIFO entries
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'd0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [31:0]             imem_resp_inst,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic [CW:0] inflight;
  logic        req_fire;
  logic        resp_live;
  logic        resp_keep;
  logic        resp_drop;
  logic        q_nonempty;
  logic        pop;
  logic        push;
  logic        bypass_take;

  // Credits cover both buffered entries and requests still in flight, so a
  // returning response always has a free slot.
  assign inflight       = {1'b0, pending} + {1'b0, count_q};
  assign imem_req_valid = !reset && !redirect_valid && (inflight < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response arriving in a redirect cycle is stale by definition.
  assign resp_live  = imem_resp_valid && !redirect_valid;
  assign resp_keep  = resp_live && (drop == '0);
  assign resp_drop  = resp_live && (drop != '0);

  assign q_nonempty = (count_q != '0);
  assign pop        = q_nonempty && out_ready && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_avail;

  assign bypass_avail = resp_keep && !q_nonempty;
  assign bypass_take  = bypass_avail && out_ready;
  assign out_valid    = q_nonempty || bypass_avail;
  assign out_pc       = bypass_avail ? resp_pc        : pc_mem[rd_ptr];
  assign out_inst     = bypass_avail ? imem_resp_inst : inst_mem[rd_ptr];
`else
  assign bypass_take  = 1'b0;
  assign out_valid    = q_nonempty;
  assign out_pc       = pc_mem[rd_ptr];
  assign out_inst     = inst_mem[rd_ptr];
`endif

  assign push  = resp_keep && !bypass_take;
  assign count = count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      pending  <= '0;
      drop     <= '0;
      count_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      count_q  <= '0;
      rd_ptr   <= wr_ptr;
      pending  <= pending - CW'(imem_resp_valid);
      // pending already counts responses that were marked for dropping by an
      // earlier redirect, so after this redirect everything still in flight
      // is stale: drop becomes exactly the remaining in-flight count. This
      // matches drop + pending - resp whenever drop was zero and stays exact
      // for back-to-back redirects.
      drop     <= pending - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      pending <= pending + CW'(req_fire) - CW'(imem_resp_valid);
      if (resp_drop) begin
        drop <= drop - CW'(1);
      end
      // resp_pc tracks every kept response, including ones taken by bypass.
      if (resp_keep) begin
        resp_pc <= resp_pc + PC_STEP;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= imem_resp_inst;
    end
  end

  // Interface sanity: memory returns nothing it was not asked for, the credit
  // scheme keeps the FIFO from overflowing, and redirect targets are aligned.
  a_resp_has_pending : assert property (
    @(posedge clock) disable iff (reset) imem_resp_valid |-> (pending != '0));

  a_no_overflow : assert property (
    @(posedge clock) disable iff (reset)
    push |-> ((count_q != CW'(DEPTH)) || pop));

  a_redirect_aligned : assert property (
    @(posedge clock) disable iff (reset)
    redirect_valid |-> (redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps

module tb_fetch_queue;

  localparam int              XLEN     = 64;
  localparam int              DEPTH    = 4;
  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] RESET_PC = 64'd0;

  logic            clock;
  logic            reset;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [CW-1:0]   count;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: memory is a queue of outstanding requests, each tagged
  // stale once a redirect overtakes it; the decode-side queue holds the
  // (pc, inst) pairs that should be visible to decode, in order.
  typedef struct { logic [XLEN-1:0] addr; bit stale; int due; } mreq_t;
  typedef struct { logic [XLEN-1:0] pc; logic [31:0] inst; } ent_t;

  mreq_t           mq[$];
  ent_t            fq[$];
  logic [XLEN-1:0] m_fetch_pc;
  int              cyc;
  int              lat_min, lat_max, resp_pct;

  logic            e_req_valid, e_out_valid, e_bypass;
  logic [XLEN-1:0] e_addr, e_out_pc;
  logic [31:0]     e_out_inst;
  logic [CW-1:0]   e_count;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] inst_of(input logic [XLEN-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_mem();
    if (!reset && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_inst  = inst_of(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_inst  = $urandom;
    end
  endtask

  task automatic eval_model();
    e_req_valid = !reset && !redirect_valid && (mq.size() + fq.size() < DEPTH);
    e_addr      = m_fetch_pc;
    e_count     = CW'(fq.size());
    e_bypass    = 1'b0;
    e_out_valid = 1'b0;
    e_out_pc    = '0;
    e_out_inst  = '0;
    if (fq.size() > 0) begin
      e_out_valid = 1'b1;
      e_out_pc    = fq[0].pc;
      e_out_inst  = fq[0].inst;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (imem_resp_valid && !redirect_valid && !mq[0].stale) begin
      e_bypass    = 1'b1;
      e_out_valid = 1'b1;
      e_out_pc    = mq[0].addr;
      e_out_inst  = imem_resp_inst;
    end
`endif
  endtask

  task automatic prep();
    drive_mem();
    #1;
    eval_model();
  endtask

  task automatic tick();
    logic  acc, popped;
    mreq_t h;
    ent_t  e;
    acc    = e_req_valid && imem_req_ready;
    popped = e_out_valid && out_ready && !redirect_valid;
    @(posedge clock);
    if (redirect_valid) begin
      fq.delete();
      foreach (mq[k]) mq[k].stale = 1'b1;
      if (imem_resp_valid) h = mq.pop_front();
      m_fetch_pc = redirect_pc;
    end else begin
      if (popped && !e_bypass) e = fq.pop_front();
      if (imem_resp_valid) begin
        h = mq.pop_front();
        if (!h.stale && !(e_bypass && popped)) begin
          e.pc   = h.addr;
          e.inst = inst_of(h.addr);
          fq.push_back(e);
        end
      end
      if (acc) begin
        h.addr  = m_fetch_pc;
        h.stale = 1'b0;
        h.due   = cyc + int'($urandom_range(lat_max, lat_min));
        mq.push_back(h);
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = '0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mq.delete(); fq.delete();
    m_fetch_pc = RESET_PC;
    cyc = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_req_ready = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_inst = '0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if ({imem_req_valid, out_valid, count} !== {1'b0, 1'b0, CW'(0)}) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", {imem_req_valid, out_valid, count}, {1'b0, 1'b0, CW'(0)});
    end
    total++;
    if (imem_req_addr !== RESET_PC) begin
      bad++; $display("FAIL reset_addr got=%h want=%h", imem_req_addr, RESET_PC);
    end
    total++;
    if ({out_pc, out_inst} !== {64'd0, 32'd0}) begin
      bad++; $display("FAIL reset_head got=%h/%h want=0/0", out_pc, out_inst);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
      bad++; $display("FAIL first_req got=%b/%h want=1/%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] seq;
    int pops;
    do_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    seq = RESET_PC; pops = 0;
    for (int i = 0; i < 24; i++) begin
      imem_req_ready = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL seq_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (e_out_valid) begin
        total++;
        if ({out_pc, out_inst} !== {seq, inst_of(seq)}) begin
          bad++; $display("FAIL seq_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, seq, inst_of(seq));
        end
        seq = seq + 64'd4; pops++;
      end
      total++;
      if (count > CW'(1)) begin
        bad++; $display("FAIL seq_count cyc=%0d got=%0d want<=1", i, count);
      end
      if (i >= 2) begin
        total++;
        if (out_valid !== 1'b1) begin
          bad++; $display("FAIL seq_gap cyc=%0d got=%b want=1", i, out_valid);
        end
      end
      tick();
    end
    total++;
    if (pops < 20) begin
      bad++; $display("FAIL seq_pops got=%0d want>=20", pops);
    end
  endtask

  task automatic test_full();
    int acc1, acc2;
    do_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    acc1 = 0; acc2 = 0;
    for (int i = 0; i < 12; i++) begin
      imem_req_ready = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL full_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (imem_req_valid && imem_req_ready) acc1++;
      tick();
    end
    #1;
    total++;
    if ({count, imem_req_valid, out_valid} !== {CW'(DEPTH), 1'b0, 1'b1}) begin
      bad++; $display("FAIL full_state got=%0d/%b/%b want=%0d/0/1", count, imem_req_valid, out_valid, DEPTH);
    end
    total++;
    if (acc1 != DEPTH) begin
      bad++; $display("FAIL full_accepts got=%0d want=%0d", acc1, DEPTH);
    end
    for (int i = 0; i < 7; i++) begin
      imem_req_ready = 1'b1; out_ready = (i == 0); redirect_valid = 1'b0;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL full_drain cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (e_out_valid) begin
        total++;
        if ({out_pc, out_inst} !== {e_out_pc, e_out_inst}) begin
          bad++; $display("FAIL full_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, e_out_pc, e_out_inst);
        end
      end
      if (i > 0 && imem_req_valid && imem_req_ready) acc2++;
      tick();
    end
    total++;
    if (acc2 != 1) begin
      bad++; $display("FAIL full_refill got=%0d want=1", acc2);
    end
  endtask

  task automatic test_ready_toggle();
    logic [XLEN-1:0] seq;
    int pops;
    do_reset();
    lat_min = 1; lat_max = 3; resp_pct = 100;
    seq = RESET_PC; pops = 0;
    for (int i = 0; i < 40; i++) begin
      imem_req_ready = (i % 2 == 0); out_ready = 1'b1; redirect_valid = 1'b0;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL tog_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (e_out_valid) begin
        total++;
        if ({out_pc, out_inst} !== {seq, inst_of(seq)}) begin
          bad++; $display("FAIL tog_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, seq, inst_of(seq));
        end
        seq = seq + 64'd4; pops++;
      end
      tick();
    end
    total++;
    if (pops < 8) begin
      bad++; $display("FAIL tog_pops got=%0d want>=8", pops);
    end
  endtask

  task automatic test_redirect();
    logic [XLEN-1:0] seq;
    int pops;
    do_reset();
    resp_pct = 100;
    seq = 64'h100; pops = 0;
    for (int i = 0; i < 24; i++) begin
      lat_min = (i < 3) ? 3 : 1;
      lat_max = (i < 3) ? 3 : 2;
      imem_req_ready = (i < 2) || (i > 3);
      out_ready = 1'b1;
      redirect_valid = (i == 3);
      redirect_pc = 64'h100;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL redir_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (i == 3) begin
        total++;
        if ({imem_resp_valid, imem_req_valid} !== 2'b10) begin
          bad++; $display("FAIL redir_cycle got=%b want=10", {imem_resp_valid, imem_req_valid});
        end
      end
      if (i == 4) begin
        total++;
        if ({out_valid, count, imem_req_addr} !== {1'b0, CW'(0), 64'h100}) begin
          bad++; $display("FAIL redir_after got=%b/%0d/%h want=0/0/100", out_valid, count, imem_req_addr);
        end
      end
      if (e_out_valid && !redirect_valid) begin
        total++;
        if ({out_pc, out_inst} !== {seq, inst_of(seq)}) begin
          bad++; $display("FAIL redir_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, seq, inst_of(seq));
        end
        seq = seq + 64'd4; pops++;
      end
      tick();
    end
    total++;
    if (pops < 2) begin
      bad++; $display("FAIL redir_pops got=%0d want>=2", pops);
    end
  endtask

  task automatic test_redirect_pop();
    logic [XLEN-1:0] seq;
    int n;
    do_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    n = 0;
    while (fq.size() < 3 && n < 20) begin
      imem_req_ready = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL rpop_fill cyc=%0d got=%h want=%h", n,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      tick();
      n++;
    end
    imem_req_ready = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h2000;
    prep();
    total++;
    if ({count, out_valid, imem_req_valid} !== {CW'(3), 1'b1, 1'b0}) begin
      bad++; $display("FAIL rpop_pre got=%0d/%b/%b want=3/1/0", count, out_valid, imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    seq = 64'h2000;
    for (int i = 0; i < 15; i++) begin
      imem_req_ready = 1'b1; out_ready = 1'b1;
      prep();
      if (i == 0) begin
        total++;
        if ({count, out_valid, imem_req_addr} !== {CW'(0), 1'b0, 64'h2000}) begin
          bad++; $display("FAIL rpop_post got=%0d/%b/%h want=0/0/2000", count, out_valid, imem_req_addr);
        end
      end
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL rpop_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (e_out_valid) begin
        total++;
        if ({out_pc, out_inst} !== {seq, inst_of(seq)}) begin
          bad++; $display("FAIL rpop_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, seq, inst_of(seq));
        end
        seq = seq + 64'd4;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] seq;
    int n, first_valid, want_first;
    do_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    n = 0;
    while (fq.size() < 3 && n < 20) begin
      imem_req_ready = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
      prep();
      tick();
      n++;
    end
    #1;
    total++;
    if (count !== CW'(3)) begin
      bad++; $display("FAIL rmid_fill got=%0d want=3", count);
    end
    reset = 1'b1;
    imem_resp_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, imem_req_valid, count, imem_req_addr} !== {1'b0, 1'b0, CW'(0), RESET_PC}) begin
      bad++; $display("FAIL rmid_async got=%b/%b/%0d/%h want=0/0/0/%h", out_valid, imem_req_valid, count, imem_req_addr, RESET_PC);
    end
    do_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
    want_first = 1;
`else
    want_first = 2;
`endif
    seq = RESET_PC; first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      imem_req_ready = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
      prep();
      if (out_valid === 1'b1 && first_valid < 0) first_valid = i;
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL rmid_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (e_out_valid) begin
        total++;
        if ({out_pc, out_inst} !== {seq, inst_of(seq)}) begin
          bad++; $display("FAIL rmid_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, seq, inst_of(seq));
        end
        seq = seq + 64'd4;
      end
      tick();
    end
    total++;
    if (first_valid != want_first) begin
      bad++; $display("FAIL rmid_first got=%0d want=%0d", first_valid, want_first);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4; resp_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(99) < 70);
      out_ready      = ($urandom_range(99) < 60);
      redirect_valid = ($urandom_range(99) < 6);
      if ($urandom_range(3) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3)) * 64'd4;
      else
        redirect_pc = 64'($urandom_range(65535)) << 2;
      prep();
      total++;
      if ({out_valid, count, imem_req_valid, imem_req_addr} !== {e_out_valid, e_count, e_req_valid, e_addr}) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got=%h want=%h", i,
          {out_valid, count, imem_req_valid, imem_req_addr}, {e_out_valid, e_count, e_req_valid, e_addr});
      end
      if (e_out_valid) begin
        total++;
        if ({out_pc, out_inst} !== {e_out_pc, e_out_inst}) begin
          bad++; $display("FAIL rand_head cyc=%0d got=%h/%h want=%h/%h", i, out_pc, out_inst, e_out_pc, e_out_inst);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    mq.delete(); fq.delete();
    m_fetch_pc = RESET_PC; cyc = 0;
    lat_min = 1; lat_max = 1; resp_pct = 100;
    test_reset();
    test_sequential();
    test_full();
    test_ready_toggle();
    test_redirect();
    test_redirect_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t total=%0d bad=%0d", $time, total, bad);
    $fatal(1);
  end

endmodule
